// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel output stage.
package vga_pkg;

  localparam int DEF_PIXEL_BITS   = 12;
  localparam int DEF_WIDTH_BITS   = 10;
  localparam int DEF_HEIGHT_BITS  = 10;
  localparam int DEF_WIDTH        = 640;
  localparam int DEF_HEIGHT       = 480;
  localparam int NUM_BARS         = 8;
  localparam int FRAME_COUNT_BITS = 16;

  typedef logic [DEF_PIXEL_BITS-1:0] colour_t;

  typedef enum logic [1:0] {
    PAT_FIG   = 2'd0,
    PAT_INV   = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/vga_pixel_output_stage_sync_delay_line.sv
// Resettable shift register of DEPTH stages; DEPTH==0 is a plain wire.
module sync_delay_line #(
  parameter int               DEPTH       = 2,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_data = i_data;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VALUE;
        end else begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_pixel_output_stage.sv
// Maps figure pixel / test patterns to colour, blanks, aligns syncs, counts frames.
// Optional blink of figure foreground enabled by defining VGA_OUT_BLINK_EN.
module vga_pixel_output_stage
  import vga_pkg::*;
#(
  parameter int                    PIXEL_BITS  = DEF_PIXEL_BITS,
  parameter int                    WIDTH_BITS  = DEF_WIDTH_BITS,
  parameter int                    HEIGHT_BITS = DEF_HEIGHT_BITS,
  parameter int                    WIDTH       = DEF_WIDTH,
  parameter int                    PIPE_STAGES = 2,
  parameter logic [PIXEL_BITS-1:0] FG_RESET    = '1,
  parameter logic [PIXEL_BITS-1:0] BG_RESET    = '0
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   pixel_bit_in,
  input  logic [WIDTH_BITS-1:0]  pixel_x_in,
  input  logic [HEIGHT_BITS-1:0] pixel_y_in,
  input  logic                   display_on_in,
  input  logic                   h_sync_in,
  input  logic                   v_sync_in,
  input  logic [PIXEL_BITS-1:0]  fg_colour_in,
  input  logic [PIXEL_BITS-1:0]  bg_colour_in,
  input  logic [1:0]             pattern_sel_in,
  input  logic                   config_load_in,
  output logic                   config_busy_out,
  output logic [PIXEL_BITS-1:0]  pixel_out,
  output logic                   h_sync_out,
  output logic                   v_sync_out,
  output logic                   display_on_out,
  output logic [15:0]            frame_count_out
);

  localparam int BAR_W = WIDTH / NUM_BARS;
  localparam int CH    = PIXEL_BITS / 3;

  cfg_state_e                  r_state;
  logic [PIXEL_BITS-1:0]       r_fg, r_bg, r_shadow_fg, r_shadow_bg;
  pattern_e                    r_pattern, r_shadow_pattern;
  logic                        r_busy;
  logic                        r_vsync_prev;
  logic [FRAME_COUNT_BITS-1:0] r_frame_count;
  logic [PIXEL_BITS-1:0]       r_pixel_s1;

  logic                  w_frame_boundary;
  logic [NUM_BARS-1:1]   w_bar_ge;
  logic [2:0]            w_bar_idx;
  logic [PIXEL_BITS-1:0] w_bar_colour;
  logic [PIXEL_BITS-1:0] w_fig_fg;
  logic [PIXEL_BITS-1:0] w_colour;
  logic                  w_unused_y;

  assign w_frame_boundary = r_vsync_prev & ~v_sync_in;
  assign w_unused_y       = ^pixel_y_in;

  // Bar index is the number of bar start columns at or left of x.
  generate
    for (genvar gi = 1; gi < NUM_BARS; gi++) begin : g_bar_cmp
      assign w_bar_ge[gi] = (pixel_x_in >= WIDTH_BITS'(gi * BAR_W));
    end
  endgenerate

  always_comb begin
    w_bar_idx = '0;
    for (int i = 1; i < NUM_BARS; i++) w_bar_idx = w_bar_idx + 3'(w_bar_ge[i]);
  end

  assign w_bar_colour = {{CH{w_bar_idx[2]}}, {CH{w_bar_idx[1]}}, {CH{w_bar_idx[0]}}};

`ifdef VGA_OUT_BLINK_EN
  assign w_fig_fg = r_frame_count[5] ? r_bg : r_fg;
`else
  assign w_fig_fg = r_fg;
`endif

  always_comb begin
    w_colour = '0;
    if (display_on_in) begin
      case (r_pattern)
        PAT_FIG:   w_colour = pixel_bit_in ? w_fig_fg : r_bg;
        PAT_INV:   w_colour = pixel_bit_in ? r_bg : w_fig_fg;
        PAT_BARS:  w_colour = w_bar_colour;
        PAT_CHECK: w_colour = (pixel_x_in[5] ^ pixel_y_in[5]) ? r_fg : r_bg;
        default:   w_colour = '0;
      endcase
    end
  end

  // A boundary commits the shadow held before this cycle; a load in the same
  // cycle is captured afterwards and waits for the following boundary.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state          <= IDLE;
      r_busy           <= 1'b0;
      r_fg             <= FG_RESET;
      r_bg             <= BG_RESET;
      r_pattern        <= PAT_FIG;
      r_shadow_fg      <= FG_RESET;
      r_shadow_bg      <= BG_RESET;
      r_shadow_pattern <= PAT_FIG;
    end else begin
      case (r_state)
        IDLE: begin
          if (config_load_in) begin
            r_shadow_fg      <= fg_colour_in;
            r_shadow_bg      <= bg_colour_in;
            r_shadow_pattern <= pattern_e'(pattern_sel_in);
            r_state          <= PENDING;
            r_busy           <= 1'b1;
          end
        end
        PENDING: begin
          if (w_frame_boundary) begin
            r_fg      <= r_shadow_fg;
            r_bg      <= r_shadow_bg;
            r_pattern <= r_shadow_pattern;
          end
          if (config_load_in) begin
            r_shadow_fg      <= fg_colour_in;
            r_shadow_bg      <= bg_colour_in;
            r_shadow_pattern <= pattern_e'(pattern_sel_in);
            r_busy           <= 1'b1;
          end else if (w_frame_boundary) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_vsync_prev  <= 1'b1;
      r_frame_count <= '0;
      r_pixel_s1    <= '0;
    end else begin
      r_vsync_prev <= v_sync_in;
      r_pixel_s1   <= w_colour;
      if (w_frame_boundary) r_frame_count <= r_frame_count + 1'b1;
    end
  end

  sync_delay_line #(
    .DEPTH       (PIPE_STAGES),
    .WIDTH       (3),
    .RESET_VALUE (3'b110)
  ) u_sync_delay (
    .i_clk  (clock_in),
    .i_rst  (reset_in),
    .i_data ({h_sync_in, v_sync_in, display_on_in}),
    .o_data ({h_sync_out, v_sync_out, display_on_out})
  );

  // The colour register above is the first pipeline stage.
  sync_delay_line #(
    .DEPTH       (PIPE_STAGES - 1),
    .WIDTH       (PIXEL_BITS),
    .RESET_VALUE ({PIXEL_BITS{1'b0}})
  ) u_pixel_delay (
    .i_clk  (clock_in),
    .i_rst  (reset_in),
    .i_data (r_pixel_s1),
    .o_data (pixel_out)
  );

  assign config_busy_out = r_busy;
  assign frame_count_out = r_frame_count;

endmodule

// File: tb/tb_vga_pixel_output_stage.sv
// Directed bench for vga_pixel_output_stage (default build, PIPE_STAGES=2).
module tb_vga_pixel_output_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic [9:0]  px = '0;
  logic [9:0]  py = '0;
  logic        disp = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic [11:0] fg_in = '0;
  logic [11:0] bg_in = '0;
  logic [1:0]  pat = '0;
  logic        load = 1'b0;

  logic        busy;
  logic [11:0] pix;
  logic        hs_o, vs_o, disp_o;
  logic [15:0] fc;

  int total = 0;
  int bad   = 0;

  vga_pixel_output_stage dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .pixel_bit_in    (bit_in),
    .pixel_x_in      (px),
    .pixel_y_in      (py),
    .display_on_in   (disp),
    .h_sync_in       (hs),
    .v_sync_in       (vs),
    .fg_colour_in    (fg_in),
    .bg_colour_in    (bg_in),
    .pattern_sel_in  (pat),
    .config_load_in  (load),
    .config_busy_out (busy),
    .pixel_out       (pix),
    .h_sync_out      (hs_o),
    .v_sync_out      (vs_o),
    .display_on_out  (disp_o),
    .frame_count_out (fc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic frame_edge();
    vs = 1'b1;
    step();
    vs = 1'b0;
    step();
  endtask

  task automatic load_cfg(input logic [11:0] f, input logic [11:0] b, input logic [1:0] p);
    fg_in = f;
    bg_in = b;
    pat   = p;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_pix", 32'(pix), 32'h000);
    chk("rst_hs", 32'(hs_o), 32'h1);
    chk("rst_vs", 32'(vs_o), 32'h1);
    chk("rst_disp", 32'(disp_o), 32'h0);
    chk("rst_fc", 32'(fc), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Figure pixel, latency of exactly two clocks
    bit_in = 1'b1; disp = 1'b1; hs = 1'b0;
    step();
    chk("lat1_pix", 32'(pix), 32'h000);
    chk("lat1_hs", 32'(hs_o), 32'h1);
    step();
    chk("t1_pix", 32'(pix), 32'hFFF);
    chk("t1_hs", 32'(hs_o), 32'h0);
    chk("t1_disp", 32'(disp_o), 32'h1);
    chk("t1_vs", 32'(vs_o), 32'h1);

    // Blanking
    disp = 1'b0; hs = 1'b1;
    step(); step();
    chk("t2_pix", 32'(pix), 32'h000);
    chk("t2_disp", 32'(disp_o), 32'h0);
    chk("t2_hs", 32'(hs_o), 32'h1);

    // Mid-frame load waits for the frame boundary
    disp = 1'b1; bit_in = 1'b1;
    load_cfg(12'hF00, 12'h000, 2'd1);
    chk("t3_busy", 32'(busy), 32'h1);
    step();
    chk("t3_old_pix", 32'(pix), 32'hFFF);
    chk("t3_busy2", 32'(busy), 32'h1);
    vs = 1'b0;
    step();
    chk("t3_busy_clr", 32'(busy), 32'h0);
    chk("t3_fc", 32'(fc), 32'h1);
    bit_in = 1'b0;
    step(); step();
    chk("t3_new_pix", 32'(pix), 32'hF00);
    chk("t3_vs", 32'(vs_o), 32'h0);

    // Load from IDLE coincident with a boundary
    vs = 1'b1;
    step();
    fg_in = 12'h00F; bg_in = 12'h000; pat = 2'd0; load = 1'b1; vs = 1'b0;
    step();
    load = 1'b0;
    chk("t4a_busy", 32'(busy), 32'h1);
    chk("t4a_fc", 32'(fc), 32'h2);
    step(); step();
    chk("t4a_old_pix", 32'(pix), 32'hF00);
    frame_edge();
    chk("t4a_busy_clr", 32'(busy), 32'h0);
    chk("t4a_fc2", 32'(fc), 32'h3);
    bit_in = 1'b1;
    step(); step();
    chk("t4a_new_pix", 32'(pix), 32'h00F);

    // Load while PENDING coincident with a boundary
    load_cfg(12'h0F0, 12'h000, 2'd0);
    chk("t4b_busy", 32'(busy), 32'h1);
    vs = 1'b1;
    step();
    fg_in = 12'hFF0; load = 1'b1; vs = 1'b0;
    step();
    load = 1'b0;
    chk("t4b_busy_kept", 32'(busy), 32'h1);
    chk("t4b_fc", 32'(fc), 32'h4);
    step(); step();
    chk("t4b_old_shadow", 32'(pix), 32'h0F0);
    frame_edge();
    chk("t4b_busy_clr", 32'(busy), 32'h0);
    step(); step();
    chk("t4b_new_pix", 32'(pix), 32'hFF0);

    // Colour bars
    load_cfg(12'h000, 12'h000, 2'd2);
    frame_edge();
    chk("t5_fc", 32'(fc), 32'h6);
    px = 10'd0;   step(); step(); chk("bar_x0", 32'(pix), 32'h000);
    px = 10'd79;  step(); step(); chk("bar_x79", 32'(pix), 32'h000);
    px = 10'd80;  step(); step(); chk("bar_x80", 32'(pix), 32'h00F);
    px = 10'd160; step(); step(); chk("bar_x160", 32'(pix), 32'h0F0);
    px = 10'd639; step(); step(); chk("bar_x639", 32'(pix), 32'hFFF);

    // Checkerboard
    load_cfg(12'hABC, 12'h123, 2'd3);
    frame_edge();
    px = 10'd32; py = 10'd0;  step(); step(); chk("chk_32_0", 32'(pix), 32'hABC);
    px = 10'd32; py = 10'd32; step(); step(); chk("chk_32_32", 32'(pix), 32'h123);
    px = 10'd0;  py = 10'd0;  step(); step(); chk("chk_0_0", 32'(pix), 32'h123);
    px = 10'd0;  py = 10'd32; step(); step(); chk("chk_0_32", 32'(pix), 32'hABC);

    // Frame counter run
    for (int i = 0; i < 1000; i++) frame_edge();
    chk("fc_1007", 32'(fc), 32'd1007);
    load_cfg(12'hF0F, 12'h0A0, 2'd0);
    frame_edge();
    chk("fc_1008", 32'(fc), 32'd1008);
    bit_in = 1'b1;
    step(); step();
    chk("no_blink_pix", 32'(pix), 32'hF0F);

    // Asynchronous reset mid-line with a pending config
    hs = 1'b0; disp = 1'b1;
    load_cfg(12'h123, 12'h456, 2'd1);
    step(); step();
    chk("pre_rst_hs", 32'(hs_o), 32'h0);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    #3 rst = 1'b1;
    #1;
    chk("arst_pix", 32'(pix), 32'h000);
    chk("arst_hs", 32'(hs_o), 32'h1);
    chk("arst_vs", 32'(vs_o), 32'h1);
    chk("arst_disp", 32'(disp_o), 32'h0);
    chk("arst_fc", 32'(fc), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    #1 rst = 1'b0;
    hs = 1'b1; vs = 1'b1;
    step(); step();
    chk("post_rst_pix", 32'(pix), 32'hFFF);
    frame_edge();
    step(); step();
    chk("post_rst_no_pending", 32'(pix), 32'hFFF);
    chk("post_rst_fc", 32'(fc), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
